// File: rtl/tenkey_debounce.sv
// -----------------------------------------------------------------------------
// tenkey_debounce
//
// Front end for the electronic lock. Takes the ten raw, bouncing keypad
// switches and produces one clean, one-cycle, one-hot 'tenkey' pulse per
// physical key press.
//
// - A press is accepted only when a single key has been stable for
//   DEBOUNCE_CYCLES cycles.
// - Chords (two or more keys) are ignored.
// - Holding a key never auto-repeats.
// - A new key is considered only after a debounced full release.
//
// Optional feature (macro TENKEY_SYNC_EN):
//   defined   : each sw_raw bit passes through a 2-flop synchronizer
//               (reset to 0), which adds 2 cycles to every latency.
//   undefined : sw_raw is used directly and must be synchronous to clk.
//
// Parameters:
//   DEBOUNCE_CYCLES : cycles a level must be stable (press and release), >= 1
//   CNT_W           : debounce counter width, 2**CNT_W >= DEBOUNCE_CYCLES
//
// Ports:
//   clk       in   system clock, rising edge
//   reset     in   asynchronous, active-high reset
//   sw_raw    in   [9:0] raw switches, 1 = pressed, bit n = digit n
//   tenkey    out  [9:0] one-hot accepted key, nonzero for one cycle per press
//   key_valid out  high in the same cycle that tenkey is nonzero
//   key_code  out  [3:0] binary digit of the last accepted key, 4'hF after reset
//   multi_key out  registered flag, high while two or more switches are sampled
//   busy      out  high while the FSM is not IDLE
// -----------------------------------------------------------------------------
module tenkey_debounce #(
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int CNT_W           = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] sw_raw,
    output logic [9:0] tenkey,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic       multi_key,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_PRESS_DB   = 2'd1,
        ST_HELD       = 2'd2,
        ST_RELEASE_DB = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Number of set bits in a switch vector (0..10).
    function automatic logic [3:0] f_count_ones(input logic [9:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 10; i++) begin
            n = n + {3'd0, v[i]};
        end
        return n;
    endfunction

    // Binary digit of a one-hot vector; 4'hF if no bit is set.
    function automatic logic [3:0] f_encode(input logic [9:0] v);
        logic [3:0] code;
        code = 4'hF;
        for (int i = 0; i < 10; i++) begin
            if (v[i]) begin
                code = 4'(i);
            end else begin
                code = code;
            end
        end
        return code;
    endfunction

    logic [9:0]       sw_s;
    logic [3:0]       ones_s;
    logic             onehot_s;
    logic             none_s;
    logic             multi_s;

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [9:0]       cand_r;
    logic [9:0]       tenkey_r;
    logic             key_valid_r;
    logic [3:0]       key_code_r;
    logic             multi_key_r;

`ifdef TENKEY_SYNC_EN
    logic [9:0] sync1_r;
    logic [9:0] sync2_r;

    // Two-flop synchronizer bringing the asynchronous switches into clk.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_r <= 10'd0;
            sync2_r <= 10'd0;
        end else begin
            sync1_r <= sw_raw;
            sync2_r <= sync1_r;
        end
    end

    assign sw_s = sync2_r;
`else
    assign sw_s = sw_raw;
`endif

    // Classify the sampled vector: exactly one key, no key, or a chord.
    always_comb begin
        ones_s   = f_count_ones(sw_s);
        onehot_s = 1'b0;
        none_s   = 1'b0;
        multi_s  = 1'b0;
        if (ones_s == 4'd1) begin
            onehot_s = 1'b1;
        end else if (ones_s == 4'd0) begin
            none_s = 1'b1;
        end else begin
            multi_s = 1'b1;
        end
    end

    // Debounce FSM with registered outputs; the pulse is cleared by default
    // every cycle so that it lasts exactly one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            cnt_r       <= '0;
            cand_r      <= 10'd0;
            tenkey_r    <= 10'd0;
            key_valid_r <= 1'b0;
            key_code_r  <= 4'hF;
            multi_key_r <= 1'b0;
        end else begin
            tenkey_r    <= 10'd0;
            key_valid_r <= 1'b0;
            multi_key_r <= multi_s;
            case (state_r)
                ST_IDLE: begin
                    // Zero and chord vectors are ignored here.
                    if (onehot_s) begin
                        cand_r  <= sw_s;
                        cnt_r   <= '0;
                        state_r <= ST_PRESS_DB;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_PRESS_DB: begin
                    // Any change (bounce, chord, different key) aborts the press.
                    if (sw_s != cand_r) begin
                        cnt_r   <= '0;
                        state_r <= ST_IDLE;
                    end else if (cnt_r == CNT_LAST) begin
                        state_r     <= ST_HELD;
                        tenkey_r    <= cand_r;
                        key_valid_r <= 1'b1;
                        key_code_r  <= f_encode(cand_r);
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_HELD: begin
                    // Adding or swapping keys while held never produces a pulse.
                    if (none_s) begin
                        cnt_r   <= '0;
                        state_r <= ST_RELEASE_DB;
                    end else begin
                        state_r <= ST_HELD;
                    end
                end
                ST_RELEASE_DB: begin
                    if (!none_s) begin
                        cnt_r   <= '0;
                        state_r <= ST_HELD;
                    end else if (cnt_r == CNT_LAST) begin
                        state_r <= ST_IDLE;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    cnt_r   <= '0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign tenkey    = tenkey_r;
    assign key_valid = key_valid_r;
    assign key_code  = key_code_r;
    assign multi_key = multi_key_r;
    assign busy      = (state_r != ST_IDLE);

endmodule
